// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - opcode constants, FSM state encodings and MUL feature switch for rpn_sequencer
//
// Purpose: shared definitions imported by rpn_alu and rpn_sequencer.
// Ports:   none (package).
// Config:  macro RPN_MUL_EN -- when defined, opcode 7 is MUL; when undefined, opcode 7 is illegal.
package rpn_pkg;

  // Opcodes carried in the low three bits of an operator token.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // Sequencer FSM state encodings.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_POP_B = 3'd1;
  localparam state_t S_POP_A = 3'd2;
  localparam state_t S_PEEK  = 3'd3;
  localparam state_t S_PUSH  = 3'd4;

`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

endpackage

// File: rtl/rpn_alu.sv
// rtl/rpn_alu.sv - combinational result generator for the RPN sequencer
//
// Purpose: computes the value to push for an operator token.
// Ports:
//   a      in  WIDTH  older stack entry
//   b      in  WIDTH  top stack entry (also the DUP value)
//   op     in  3      opcode
//   result out WIDTH  a op b, modulo 2^WIDTH; b for DUP/DROP
// Config: macro RPN_MUL_EN enables opcode 7 (low WIDTH bits of a*b).
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // Pass-through of b covers DUP (push the peeked top) and DROP (unused).
    result = b;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`ifdef RPN_MUL_EN
      // WIDTH-bit context keeps only the low bits of the product.
      OP_MUL: result = a * b;
`endif
      default: result = b;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - reverse-Polish token evaluator driving an external 8-bit stack
//
// Purpose: accepts operand/operator tokens, sequences pop/pop/push on the stack,
//          tracks occupancy locally and raises sticky error flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tok_valid/tok_ready        token handshake (ready only in IDLE)
//   tok_is_op, tok_data        token kind and operand value / opcode (low 3 bits)
//   stk_push, stk_pop          one-cycle stack strobes, never together
//   stk_data_in, stk_data_out  value pushed / current stack top
//   res_valid, res_data        operator result pulse and held value
//   depth                      current stack occupancy
//   err_underflow/overflow/illegal  sticky errors, cleared by err_clr
// Config: macro RPN_MUL_EN (see rpn_pkg) selects MUL vs illegal for opcode 7.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] depth,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             err_illegal,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic             ready_q;
  logic             is_op_q, is_op_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             unf_q, unf_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic             accept;
  logic [2:0]       tok_op;
  logic             is_empty, is_full, lt_two;
  logic [WIDTH-1:0] alu_result;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

  assign accept   = tok_valid & ready_q;
  assign tok_op   = tok_data[2:0];
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == FULL);
  assign lt_two   = is_empty | (depth_q == CNT_W'(1));

  // Strobes decode straight from the state register so an async reset
  // forces them low immediately.
  assign stk_push    = (state_q == S_PUSH);
  assign stk_pop     = (state_q == S_POP_B) | (state_q == S_POP_A);
  assign res_valid   = stk_push & is_op_q;
  // Operand pushes reuse b_q as the holding register.
  assign stk_data_in = stk_push ? (is_op_q ? alu_result : b_q) : '0;
  // Result is visible in the same cycle as its pulse, then held.
  assign res_data    = res_valid ? alu_result : res_q;

  assign tok_ready     = ready_q;
  assign depth         = depth_q;
  assign err_underflow = unf_q;
  assign err_overflow  = ovf_q;
  assign err_illegal   = ill_q;

  always_comb begin
    state_d = state_q;
    is_op_d = is_op_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    // Clear first so a same-cycle error re-sets its flag.
    unf_d   = unf_q & ~err_clr;
    ovf_d   = ovf_q & ~err_clr;
    ill_d   = ill_q & ~err_clr;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!tok_is_op) begin
            if (is_full) begin
              ovf_d = 1'b1;
            end else begin
              is_op_d = 1'b0;
              b_d     = tok_data;
              state_d = S_PUSH;
            end
          end else begin
            is_op_d = 1'b1;
            op_d    = tok_op;
            if (tok_op == OP_MUL && !MUL_EN) begin
              ill_d = 1'b1;
            end else if (tok_op == OP_DUP) begin
              if (is_empty)     unf_d   = 1'b1;
              else if (is_full) ovf_d   = 1'b1;
              else              state_d = S_PEEK;
            end else if (tok_op == OP_DROP) begin
              if (is_empty) unf_d   = 1'b1;
              else          state_d = S_POP_B;
            end else begin
              if (lt_two) unf_d   = 1'b1;
              else        state_d = S_POP_B;
            end
          end
        end
      end
      S_POP_B: begin
        b_d     = stk_data_out;
        state_d = (op_q == OP_DROP) ? S_IDLE : S_POP_A;
      end
      S_POP_A: begin
        a_d     = stk_data_out;
        state_d = S_PUSH;
      end
      S_PEEK: begin
        b_d     = stk_data_out;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (is_op_q) res_d = alu_result;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    if (stk_push)     depth_d = depth_q + CNT_W'(1);
    else if (stk_pop) depth_d = depth_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      is_op_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      depth_q <= '0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      is_op_q <= is_op_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      depth_q <= depth_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
Token-driven controller that sits directly upstream of the 8-bit stack and owns its push/pop/data_in lines. Accepts a stream of operand/operator tokens over valid/ready and evaluates them in reverse-Polish order. Binary ops pop two entries, compute, and push the result. Tracks stack depth locally to flag underflow/overflow before touching the stack.

Parameters:
WIDTH, 8, data width of operands, results and the stack word
DEPTH, 8, stack capacity in entries; must match the attached stack
CNT_W, $clog2(DEPTH+1), width of the depth counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token present
tok_ready  out  1  sequencer accepts token this cycle
tok_is_op  in  1  1 = tok_data is an opcode, 0 = operand
tok_data  in  WIDTH  operand value or opcode (low 3 bits)
stk_push  out  1  push to stack (one-cycle pulse)
stk_pop  out  1  pop from stack (one-cycle pulse)
stk_data_in  out  WIDTH  value pushed
stk_data_out  in  WIDTH  stack top; valid the cycle after any push/pop edge
res_valid  out  1  one-cycle pulse when an op result is pushed
res_data  out  WIDTH  result value, held until next res_valid
depth  out  CNT_W  current stack occupancy
err_underflow  out  1  sticky
err_overflow  out  1  sticky
err_illegal  out  1  sticky
err_clr  in  1  synchronous clear of all sticky errors

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; depth 0. Reset mid-operation abandons the op; no further push/pop issued. The stack must be reset alongside.
- Opcodes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 DUP, 6 DROP, 7 MUL (optional). a = older entry, b = top. Arithmetic is modulo 2^WIDTH; no carry or overflow flag.
- tok_ready = 1 only in IDLE. Handshake is tok_valid & tok_ready.
- FSM states: IDLE, POP_B, POP_A, PEEK, PUSH.
- Operand accepted at T:
  - If depth==DEPTH: err_overflow=1, token dropped, stay IDLE.
  - Otherwise PUSH at T+1: stk_push=1, stk_data_in=operand, depth+1.
- Binary op accepted at T:
  - If depth<2: err_underflow=1, token dropped, no stack activity.
  - Otherwise:
    - T+1 POP_B: b<=stk_data_out, stk_pop=1.
    - T+2 POP_A: a<=stk_data_out, stk_pop=1.
    - T+3 PUSH: stk_push=1 with result; res_valid=1; res_data=result.
  - Net depth change -1. tok_ready returns at T+4.
- DUP: needs depth>=1 else underflow; also needs depth<DEPTH else overflow. T+1 PEEK captures top; T+2 PUSH pushes it; res_valid pulses.
- DROP: needs depth>=1 else underflow. T+1 POP_B pops, result discarded; no res_valid.
- stk_push and stk_pop are never asserted in the same cycle.
- Checked errors leave stack contents and depth unchanged.
- err_clr and a new error in the same cycle: the error wins.

Optional Feature:
RPN_MUL_EN
- Defined: opcode 7 = MUL, low WIDTH bits of a*b, same timing as the other binary ops.
- Undefined: opcode 7 sets err_illegal; token dropped; no stack activity.

Decomposition:
- Package rpn_pkg holds the opcode constants (OP_ADD..OP_MUL) and the FSM state enum.
- One sub-module, rpn_alu: combinational, inputs a, b, op; output result. MUL is gated by RPN_MUL_EN.
- Top holds the FSM, depth counter and error flags.

Test Plan:
- Push 7, push 5, ADD -> stk_push with 12 at T+3; res_valid=1; res_data=12; depth=1.
- Push 5, push 7, SUB -> result 8'd254 (wrap); then DUP -> depth=2, res_data=254.
- Push 3 only, ADD -> err_underflow=1; stk_pop never asserted; depth=1; err_clr clears the flag.
- DEPTH=4: push 1..5 -> fifth push sets err_overflow; depth=4; stk_push pulsed exactly 4 times.
- Assert rst_n=0 during POP_A of an ADD -> all outputs 0 immediately; IDLE after release; tok_ready=1.
- Push 20, push 13, opcode 7 -> with RPN_MUL_EN, result 4 (260 mod 256); without it, err_illegal=1 and depth=2.
